// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared types for the LETC core decode stage: basic word/register types, the
// RV32 major opcode enumeration, the instruction format enumeration, the
// decoded instruction record that travels from decode to execute, and the
// helper that builds the immediate for a given format.
// No ports (package).
// -----------------------------------------------------------------------------
package core_pkg;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  reg_index_t;

   // Major opcode field instr[6:2]; the two low bits are always 2'b11 for
   // legal 32-bit encodings and are checked separately.
   typedef enum logic [4:0] {
      OPCODE_LOAD     = 5'b00000,
      OPCODE_MISC_MEM = 5'b00011,
      OPCODE_OP_IMM   = 5'b00100,
      OPCODE_AUIPC    = 5'b00101,
      OPCODE_STORE    = 5'b01000,
      OPCODE_AMO      = 5'b01011,
      OPCODE_OP       = 5'b01100,
      OPCODE_LUI      = 5'b01101,
      OPCODE_BRANCH   = 5'b11000,
      OPCODE_JALR     = 5'b11001,
      OPCODE_JAL      = 5'b11011,
      OPCODE_SYSTEM   = 5'b11100
   } opcode_e;

   typedef enum logic [2:0] {
      FMT_R    = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_UIMM = 3'd6
   } instr_format_e;

   // Occupancy of the output register plus skid register in core_decode.
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occupancy_e;

   typedef struct packed {
      word_t         pc;
      opcode_e       opcode;
      reg_index_t    rd;
      reg_index_t    rs1;
      reg_index_t    rs2;
      logic [2:0]    funct3;
      logic [6:0]    funct7;
      word_t         imm;
      instr_format_e format;
      logic          illegal;
   } decoded_instr_s;

   // Immediate assembly per format; every signed form sign-extends from
   // instr[31], while UIMM (CSR immediate forms) zero-extends the rs1 field.
   function automatic word_t imm_from_instr(input word_t instr, input instr_format_e fmt);
      word_t imm;
      imm = '0;
      case (fmt)
         FMT_I:    imm = {{20{instr[31]}}, instr[31:20]};
         FMT_S:    imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:    imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_U:    imm = {instr[31:12], 12'b0};
         FMT_J:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         FMT_UIMM: imm = {27'b0, instr[19:15]};
         default:  imm = '0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/core_instr_field_decode.sv
// -----------------------------------------------------------------------------
// core_instr_field_decode
// Purely combinational split of a raw RV32 instruction word into its fields,
// format, immediate and illegal flag.
// Ports:
//   instr   in  32  raw instruction word
//   pc      in  32  PC carried alongside the word
//   decoded out     decoded_instr_s record for the word
// -----------------------------------------------------------------------------
module core_instr_field_decode
   import core_pkg::*;
(
   input  word_t          instr,
   input  word_t          pc,
   output decoded_instr_s decoded
);

   instr_format_e fmt;
   logic          legal;

   // Format lookup from the major opcode; anything outside the map, or a
   // compressed/invalid low-bit pattern, is flagged illegal and forced to R
   // with a zero immediate so execute never sees a half-built immediate.
   always_comb begin
      fmt   = FMT_R;
      legal = 1'b1;
      if (instr[1:0] != 2'b11) begin
         legal = 1'b0;
      end else begin
         case (instr[6:2])
            OPCODE_OP, OPCODE_AMO:                               fmt = FMT_R;
            OPCODE_LOAD, OPCODE_OP_IMM, OPCODE_JALR, OPCODE_MISC_MEM: fmt = FMT_I;
            OPCODE_SYSTEM:                                       fmt = instr[14] ? FMT_UIMM : FMT_I;
            OPCODE_STORE:                                        fmt = FMT_S;
            OPCODE_BRANCH:                                       fmt = FMT_B;
            OPCODE_LUI, OPCODE_AUIPC:                            fmt = FMT_U;
            OPCODE_JAL:                                          fmt = FMT_J;
            default:                                             legal = 1'b0;
         endcase
      end

      decoded         = '0;
      decoded.pc      = pc;
      decoded.opcode  = opcode_e'(instr[6:2]);
      decoded.rd      = instr[11:7];
      decoded.rs1     = instr[19:15];
      decoded.rs2     = instr[24:20];
      decoded.funct3  = instr[14:12];
      decoded.funct7  = instr[31:25];
      decoded.format  = legal ? fmt : FMT_R;
      decoded.imm     = legal ? imm_from_instr(instr, fmt) : '0;
      decoded.illegal = ~legal;
   end

endmodule

// File: rtl/core_decode.sv
// -----------------------------------------------------------------------------
// core_decode
// Decode stage of the LETC core. Decodes each fetched RV32 word and hands the
// registered result to execute over valid/ready. An output register plus one
// skid register give full throughput while f2d_ready stays a flop output.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   flush                  synchronous flush, drops every held entry
//   f2d_valid/ready        fetch handshake (ready is registered)
//   f2d_instr, f2d_pc      raw instruction word and its PC
//   d2e_valid/ready        execute handshake
//   d2e_pc .. d2e_illegal  decoded fields of the entry at the output
// -----------------------------------------------------------------------------
module core_decode
   import core_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        f2d_valid,
   output logic        f2d_ready,
   input  logic [31:0] f2d_instr,
   input  logic [31:0] f2d_pc,
   output logic        d2e_valid,
   input  logic        d2e_ready,
   output logic [31:0] d2e_pc,
   output logic [4:0]  d2e_opcode,
   output logic [4:0]  d2e_rd,
   output logic [4:0]  d2e_rs1,
   output logic [4:0]  d2e_rs2,
   output logic [2:0]  d2e_funct3,
   output logic [6:0]  d2e_funct7,
   output logic [31:0] d2e_imm,
   output logic [2:0]  d2e_format,
   output logic        d2e_illegal
);

   decoded_instr_s in_dec;
   decoded_instr_s out_q;
   decoded_instr_s skid_q;
   occupancy_e     state;
   occupancy_e     state_next;
   logic           ready_q;
   logic           accept;
   logic           drain;
   logic           load_out_in;
   logic           load_out_skid;
   logic           load_skid;

   core_instr_field_decode u_field_decode (
      .instr   (f2d_instr),
      .pc      (f2d_pc),
      .decoded (in_dec)
   );

   assign f2d_ready = ready_q;
   assign d2e_valid = (state != OCC_EMPTY);
   assign accept    = f2d_valid && ready_q;
   assign drain     = d2e_valid && d2e_ready;

   // Occupancy next-state and register load enables. The output register is
   // always the oldest entry; the skid register only fills when a beat is
   // accepted while the output is stalled, which keeps the order FIFO.
   always_comb begin
      state_next    = state;
      load_out_in   = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
      if (flush) begin
         state_next = OCC_EMPTY;
      end else begin
         case (state)
            OCC_EMPTY: begin
               if (accept) begin
                  state_next  = OCC_ONE;
                  load_out_in = 1'b1;
               end
            end
            OCC_ONE: begin
               if (accept && !drain) begin
                  state_next = OCC_TWO;
                  load_skid  = 1'b1;
               end else if (drain && !accept) begin
                  state_next = OCC_EMPTY;
               end else if (drain && accept) begin
                  load_out_in = 1'b1;
               end
            end
            OCC_TWO: begin
               if (drain) begin
                  state_next    = OCC_ONE;
                  load_out_skid = 1'b1;
               end
            end
            default: state_next = OCC_EMPTY;
         endcase
      end
   end

   // State and registered ready; ready is computed from the next state so
   // it falls the cycle after the skid fills and is back up after a drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= OCC_EMPTY;
         ready_q <= 1'b1;
      end else begin
         state   <= state_next;
         ready_q <= (state_next != OCC_TWO);
      end
   end

   // Data registers hold decoded fields rather than the raw word, so execute
   // sees stable fields while stalled and no decode sits on the output path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q  <= '0;
         skid_q <= '0;
      end else begin
         if (load_out_in) begin
            out_q <= in_dec;
         end else if (load_out_skid) begin
            out_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_dec;
         end
      end
   end

   assign d2e_pc      = out_q.pc;
   assign d2e_opcode  = out_q.opcode;
   assign d2e_rd      = out_q.rd;
   assign d2e_rs1     = out_q.rs1;
   assign d2e_rs2     = out_q.rs2;
   assign d2e_funct3  = out_q.funct3;
   assign d2e_funct7  = out_q.funct7;
   assign d2e_imm     = out_q.imm;
   assign d2e_format  = out_q.format;
   assign d2e_illegal = out_q.illegal;

endmodule

// File: tb/tb_core_decode.sv
// -----------------------------------------------------------------------------
// tb_core_decode
// Scoreboard bench for core_decode: expected decoded entries are queued when
// fetch hands a beat over and compared in order when execute takes one.
// -----------------------------------------------------------------------------
module tb_core_decode;
   import core_pkg::*;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [2:0]  fmt;
      logic        ill;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        f2d_valid;
   logic        f2d_ready;
   logic [31:0] f2d_instr;
   logic [31:0] f2d_pc;
   logic        d2e_valid;
   logic        d2e_ready;
   logic [31:0] d2e_pc;
   logic [4:0]  d2e_opcode;
   logic [4:0]  d2e_rd;
   logic [4:0]  d2e_rs1;
   logic [4:0]  d2e_rs2;
   logic [2:0]  d2e_funct3;
   logic [6:0]  d2e_funct7;
   logic [31:0] d2e_imm;
   logic [2:0]  d2e_format;
   logic        d2e_illegal;

   exp_t sb[$];
   int   checkCount = 0;
   int   failCount  = 0;

   core_decode dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .f2d_valid   (f2d_valid),
      .f2d_ready   (f2d_ready),
      .f2d_instr   (f2d_instr),
      .f2d_pc      (f2d_pc),
      .d2e_valid   (d2e_valid),
      .d2e_ready   (d2e_ready),
      .d2e_pc      (d2e_pc),
      .d2e_opcode  (d2e_opcode),
      .d2e_rd      (d2e_rd),
      .d2e_rs1     (d2e_rs1),
      .d2e_rs2     (d2e_rs2),
      .d2e_funct3  (d2e_funct3),
      .d2e_funct7  (d2e_funct7),
      .d2e_imm     (d2e_imm),
      .d2e_format  (d2e_format),
      .d2e_illegal (d2e_illegal)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", tag, act, exp);
      end
   endtask

   // Independent reference decode, written from the RV32 7-bit opcode view.
   function automatic exp_t refDecode(input logic [31:0] instr, input logic [31:0] pc);
      exp_t e;
      logic [2:0] fmt;
      logic ill;
      ill = 1'b0;
      fmt = FMT_R;
      case (instr[6:0])
         7'h33, 7'h2F:               fmt = FMT_R;
         7'h03, 7'h13, 7'h67, 7'h0F: fmt = FMT_I;
         7'h73:                      fmt = (instr[14] == 1'b1) ? FMT_UIMM : FMT_I;
         7'h23:                      fmt = FMT_S;
         7'h63:                      fmt = FMT_B;
         7'h37, 7'h17:               fmt = FMT_U;
         7'h6F:                      fmt = FMT_J;
         default:                    ill = 1'b1;
      endcase
      e.pc = pc;
      e.opcode = instr[6:2];
      e.rd = instr[11:7];
      e.rs1 = instr[19:15];
      e.rs2 = instr[24:20];
      e.f3 = instr[14:12];
      e.f7 = instr[31:25];
      e.ill = ill;
      e.fmt = ill ? 3'(FMT_R) : fmt;
      e.imm = 32'h0;
      if (!ill) begin
         case (fmt)
            FMT_I:    e.imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S:    e.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:    e.imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:    e.imm = {instr[31:12], 12'h000};
            FMT_J:    e.imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            FMT_UIMM: e.imm = {27'h0, instr[19:15]};
            default:  e.imm = 32'h0;
         endcase
      end
      return e;
   endfunction

   // Entry with literal opcode/imm/format/illegal; register fields from the word.
   function automatic exp_t mkExp(input logic [31:0] instr, input logic [31:0] pc,
                                  input logic [4:0] op, input logic [31:0] imm,
                                  input logic [2:0] fmt, input logic ill);
      exp_t e;
      e.pc = pc;
      e.opcode = op;
      e.rd = instr[11:7];
      e.rs1 = instr[19:15];
      e.rs2 = instr[24:20];
      e.f3 = instr[14:12];
      e.f7 = instr[31:25];
      e.imm = imm;
      e.fmt = fmt;
      e.ill = ill;
      return e;
   endfunction

   task automatic compareHead();
      exp_t e;
      if (sb.size() == 0) begin
         checkOutput("unexpected_out", {31'h0, d2e_valid}, 32'h0);
      end else begin
         e = sb.pop_front();
         checkOutput("pc", d2e_pc, e.pc);
         checkOutput("opcode", {27'h0, d2e_opcode}, {27'h0, e.opcode});
         checkOutput("rd", {27'h0, d2e_rd}, {27'h0, e.rd});
         checkOutput("rs1", {27'h0, d2e_rs1}, {27'h0, e.rs1});
         checkOutput("rs2", {27'h0, d2e_rs2}, {27'h0, e.rs2});
         checkOutput("funct3", {29'h0, d2e_funct3}, {29'h0, e.f3});
         checkOutput("funct7", {25'h0, d2e_funct7}, {25'h0, e.f7});
         checkOutput("imm", d2e_imm, e.imm);
         checkOutput("format", {29'h0, d2e_format}, {29'h0, e.fmt});
         checkOutput("illegal", {31'h0, d2e_illegal}, {31'h0, e.ill});
      end
   endtask

   // Called at a falling edge: drive one cycle, observe the handshakes just
   // after, update the scoreboard, and return at the next falling edge.
   task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                input logic rdy, input logic fl, input exp_t e);
      f2d_valid = v;
      f2d_instr = instr;
      f2d_pc    = pc;
      d2e_ready = rdy;
      flush     = fl;
      #1;
      if (fl) begin
         sb.delete();
      end else begin
         if (d2e_valid && d2e_ready) compareHead();
         if (f2d_valid && f2d_ready) sb.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic rdy);
      applyStimulus(1'b0, 32'h0, 32'h0, rdy, 1'b0, refDecode(32'h0, 32'h0));
   endtask

   localparam logic [31:0] ADDI = 32'h00500093;

   initial begin
      logic [31:0] pend;
      logic [31:0] pcR;
      logic [31:0] rnd;
      logic        have;
      logic        v;
      logic        rdy;
      logic        acc;
      logic [6:0]  ops [14];
      ops = '{7'h33, 7'h2F, 7'h03, 7'h13, 7'h67, 7'h0F, 7'h73,
              7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h01};

      rst_n = 1'b0;
      flush = 1'b0;
      f2d_valid = 1'b0;
      f2d_instr = 32'h0;
      f2d_pc = 32'h0;
      d2e_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset_d2e_valid", {31'h0, d2e_valid}, 32'h0);
      checkOutput("reset_f2d_ready", {31'h0, f2d_ready}, 32'h1);
      checkOutput("reset_pc", d2e_pc, 32'h0);
      checkOutput("reset_imm", d2e_imm, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed decodes with literal expectations, one-cycle latency.
      applyStimulus(1'b1, ADDI, 32'h1000, 1'b1, 1'b0, mkExp(ADDI, 32'h1000, 5'b00100, 32'h5, FMT_I, 1'b0));
      checkOutput("latency_valid", {31'h0, d2e_valid}, 32'h1);
      checkOutput("addi_rd", {27'h0, d2e_rd}, 32'h1);
      applyStimulus(1'b1, 32'hFE000EE3, 32'h1004, 1'b1, 1'b0, mkExp(32'hFE000EE3, 32'h1004, 5'b11000, 32'hFFFFFFFC, FMT_B, 1'b0));
      applyStimulus(1'b1, 32'h008000EF, 32'h1008, 1'b1, 1'b0, mkExp(32'h008000EF, 32'h1008, 5'b11011, 32'h8, FMT_J, 1'b0));
      applyStimulus(1'b1, 32'h12345137, 32'h100C, 1'b1, 1'b0, mkExp(32'h12345137, 32'h100C, 5'b01101, 32'h12345000, FMT_U, 1'b0));
      applyStimulus(1'b1, 32'h3002D073, 32'h1010, 1'b1, 1'b0, mkExp(32'h3002D073, 32'h1010, 5'b11100, 32'h5, FMT_UIMM, 1'b0));
      applyStimulus(1'b1, 32'h00000000, 32'h1014, 1'b1, 1'b0, mkExp(32'h00000000, 32'h1014, 5'b00000, 32'h0, FMT_R, 1'b1));
      idle(1'b1);
      checkOutput("directed_drained", sb.size(), 32'h0);

      // Backpressure: two beats fill the stage, the third is held by fetch.
      applyStimulus(1'b1, ADDI, 32'h0, 1'b0, 1'b0, refDecode(ADDI, 32'h0));
      applyStimulus(1'b1, 32'h00A00113, 32'h4, 1'b0, 1'b0, refDecode(32'h00A00113, 32'h4));
      checkOutput("bp_ready_low", {31'h0, f2d_ready}, 32'h0);
      applyStimulus(1'b1, 32'h00F00193, 32'h8, 1'b0, 1'b0, refDecode(32'h00F00193, 32'h8));
      checkOutput("bp_hold_pc", d2e_pc, 32'h0);
      checkOutput("bp_ready_still_low", {31'h0, f2d_ready}, 32'h0);
      applyStimulus(1'b1, 32'h00F00193, 32'h8, 1'b1, 1'b0, refDecode(32'h00F00193, 32'h8));
      checkOutput("bp_ready_back", {31'h0, f2d_ready}, 32'h1);
      checkOutput("bp_next_valid", {31'h0, d2e_valid}, 32'h1);
      applyStimulus(1'b1, 32'h00F00193, 32'h8, 1'b1, 1'b0, refDecode(32'h00F00193, 32'h8));
      checkOutput("bp_third_valid", {31'h0, d2e_valid}, 32'h1);
      idle(1'b1);
      checkOutput("bp_empty_valid", {31'h0, d2e_valid}, 32'h0);
      checkOutput("bp_drained", sb.size(), 32'h0);

      // Flush while full, with a beat offered in the flush cycle.
      applyStimulus(1'b1, ADDI, 32'h20, 1'b0, 1'b0, refDecode(ADDI, 32'h20));
      applyStimulus(1'b1, ADDI, 32'h24, 1'b0, 1'b0, refDecode(ADDI, 32'h24));
      applyStimulus(1'b1, ADDI, 32'h100, 1'b0, 1'b1, refDecode(ADDI, 32'h100));
      checkOutput("flush_valid", {31'h0, d2e_valid}, 32'h0);
      checkOutput("flush_ready", {31'h0, f2d_ready}, 32'h1);
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);

      // Asynchronous reset in the middle of a stalled stream.
      applyStimulus(1'b1, 32'h12345137, 32'h40, 1'b0, 1'b0, refDecode(32'h12345137, 32'h40));
      applyStimulus(1'b1, ADDI, 32'h44, 1'b0, 1'b0, refDecode(ADDI, 32'h44));
      f2d_valid = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_valid", {31'h0, d2e_valid}, 32'h0);
      checkOutput("rst_mid_ready", {31'h0, f2d_ready}, 32'h1);
      checkOutput("rst_mid_imm", d2e_imm, 32'h0);
      checkOutput("rst_mid_pc", d2e_pc, 32'h0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(1'b1, ADDI, 32'h80, 1'b1, 1'b0, mkExp(ADDI, 32'h80, 5'b00100, 32'h5, FMT_I, 1'b0));
      checkOutput("post_rst_valid", {31'h0, d2e_valid}, 32'h1);
      idle(1'b1);

      // Random traffic on both handshakes; fetch holds a word until taken.
      have = 1'b0;
      pend = 32'h0;
      pcR  = 32'h2000;
      for (int i = 0; i < 60; i++) begin
         if (!have) begin
            rnd  = $urandom;
            pend = {rnd[31:7], ops[$urandom_range(0, 13)]};
            pcR  = pcR + 32'd4;
            have = 1'b1;
         end
         v   = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 2) != 0);
         acc = v && f2d_ready;
         applyStimulus(v, pend, pcR, rdy, 1'b0, refDecode(pend, pcR));
         if (acc) have = 1'b0;
      end
      for (int i = 0; i < 10; i++) begin
         if (sb.size() != 0) idle(1'b1);
      end
      checkOutput("random_drained", sb.size(), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
